// File: rtl/mem_access_stage.sv
// mem_access_stage
// Memory-access stage between execute and writeback. Accepts one instruction
// at a time. LDW/STW run a req/ack transaction with data memory, bounded by a
// TIMEOUT-cycle wait. Every instruction ends in a registered one-cycle
// wb_valid pulse carrying the from_mem / not_from_mem / opcode / dst bundle.
// Non-memory and misaligned instructions complete one cycle after accept.
//
// Parameters:
//   TIMEOUT        cycles mem_req may wait for mem_ack (1..255)
//   OP_LDW/OP_STW  load/store opcode encodings of the core's ISA
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready          instruction handshake from execute
//   in_opcode, in_alu_result,
//   in_store_data, in_dst      instruction fields
//   mem_req/mem_we/mem_addr/
//   mem_wdata                  registered request to data memory
//   mem_ack/mem_rdata          memory completion and read data
//   wb_valid                   one-cycle pulse: wb_* bundle is new
//   wb_opcode, wb_from_mem,
//   wb_not_from_mem, wb_dst,
//   wb_fault                   writeback bundle (held between pulses)
module mem_access_stage #(
    parameter int unsigned TIMEOUT = 255,
    parameter logic [5:0]  OP_LDW  = 6'h23,
    parameter logic [5:0]  OP_STW  = 6'h2B
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  in_opcode,
    input  logic [31:0] in_alu_result,
    input  logic [31:0] in_store_data,
    input  logic [4:0]  in_dst,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [5:0]  wb_opcode,
    output logic [31:0] wb_from_mem,
    output logic [31:0] wb_not_from_mem,
    output logic [4:0]  wb_dst,
    output logic        wb_fault
);

    typedef enum logic {IDLE, BUSY} state_e;

    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [5:0]  op_q, op_d;
    logic [4:0]  dst_q, dst_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        wb_valid_q, wb_valid_d;
    logic [5:0]  wb_opcode_q, wb_opcode_d;
    logic [31:0] wb_from_mem_q, wb_from_mem_d;
    logic [31:0] wb_not_from_mem_q, wb_not_from_mem_d;
    logic [4:0]  wb_dst_q, wb_dst_d;
    logic        wb_fault_q, wb_fault_d;

    logic accept;
    logic in_is_mem;
    logic in_misaligned;
    logic start_mem;
    logic done_ack;
    logic done_timeout;

    assign in_ready      = (state_q == IDLE);
    assign accept        = in_valid & in_ready;
    assign in_is_mem     = (in_opcode == OP_LDW) || (in_opcode == OP_STW);
    assign in_misaligned = (in_alu_result[1:0] != 2'b00);
    assign start_mem     = accept & in_is_mem & ~in_misaligned;
    // Ack in the last wait cycle wins over the timeout.
    assign done_ack      = (state_q == BUSY) & mem_ack;
    assign done_timeout  = (state_q == BUSY) & ~mem_ack & (cnt_q == LAST_CNT);

    // State register and all datapath flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= IDLE;
            cnt_q             <= '0;
            op_q              <= '0;
            dst_q             <= '0;
            mem_req_q         <= 1'b0;
            mem_we_q          <= 1'b0;
            mem_addr_q        <= '0;
            mem_wdata_q       <= '0;
            wb_valid_q        <= 1'b0;
            wb_opcode_q       <= '0;
            wb_from_mem_q     <= '0;
            wb_not_from_mem_q <= '0;
            wb_dst_q          <= '0;
            wb_fault_q        <= 1'b0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            op_q              <= op_d;
            dst_q             <= dst_d;
            mem_req_q         <= mem_req_d;
            mem_we_q          <= mem_we_d;
            mem_addr_q        <= mem_addr_d;
            mem_wdata_q       <= mem_wdata_d;
            wb_valid_q        <= wb_valid_d;
            wb_opcode_q       <= wb_opcode_d;
            wb_from_mem_q     <= wb_from_mem_d;
            wb_not_from_mem_q <= wb_not_from_mem_d;
            wb_dst_q          <= wb_dst_d;
            wb_fault_q        <= wb_fault_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_mem) state_d = BUSY;
            BUSY:    if (done_ack || done_timeout) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        cnt_d             = cnt_q;
        op_d              = op_q;
        dst_d             = dst_q;
        mem_req_d         = mem_req_q;
        mem_we_d          = mem_we_q;
        mem_addr_d        = mem_addr_q;
        mem_wdata_d       = mem_wdata_q;
        wb_valid_d        = 1'b0;
        wb_opcode_d       = wb_opcode_q;
        wb_from_mem_d     = wb_from_mem_q;
        wb_not_from_mem_d = wb_not_from_mem_q;
        wb_dst_d          = wb_dst_q;
        wb_fault_d        = wb_fault_q;

        case (state_q)
            IDLE: begin
                if (start_mem) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = (in_opcode == OP_STW);
                    mem_addr_d  = in_alu_result;
                    mem_wdata_d = in_store_data;
                    op_d        = in_opcode;
                    dst_d       = in_dst;
                    cnt_d       = '0;
                end else if (accept) begin
                    // Non-memory op or misaligned access: complete immediately
                    wb_valid_d        = 1'b1;
                    wb_opcode_d       = in_opcode;
                    wb_from_mem_d     = '0;
                    wb_not_from_mem_d = in_alu_result;
                    wb_dst_d          = in_dst;
                    wb_fault_d        = in_is_mem;
                end
            end
            BUSY: begin
                if (done_ack || done_timeout) begin
                    mem_req_d   = 1'b0;
                    wb_valid_d  = 1'b1;
                    wb_opcode_d = op_q;
                    // mem_addr_q holds the latched ALU result for the whole access
                    wb_not_from_mem_d = mem_addr_q;
                    wb_dst_d          = dst_q;
                    wb_fault_d        = done_timeout;
                    wb_from_mem_d     = (done_ack && !mem_we_q) ? mem_rdata : '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    assign mem_req         = mem_req_q;
    assign mem_we          = mem_we_q;
    assign mem_addr        = mem_addr_q;
    assign mem_wdata       = mem_wdata_q;
    assign wb_valid        = wb_valid_q;
    assign wb_opcode       = wb_opcode_q;
    assign wb_from_mem     = wb_from_mem_q;
    assign wb_not_from_mem = wb_not_from_mem_q;
    assign wb_dst          = wb_dst_q;
    assign wb_fault        = wb_fault_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage (TIMEOUT = 4). A responder model drives
// mem_ack after a chosen number of wait cycles; expected wb bundle, latency
// and request duration are computed from the stage's cycle rules.
module tb_mem_access_stage;

    localparam int unsigned TO  = 4;
    localparam logic [5:0]  LDW = 6'h23;
    localparam logic [5:0]  STW = 6'h2B;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_opcode;
    logic [31:0] in_alu_result;
    logic [31:0] in_store_data;
    logic [4:0]  in_dst;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [5:0]  wb_opcode;
    logic [31:0] wb_from_mem;
    logic [31:0] wb_not_from_mem;
    logic [4:0]  wb_dst;
    logic        wb_fault;

    int total;
    int bad;

    mem_access_stage #(
        .TIMEOUT (TO),
        .OP_LDW  (LDW),
        .OP_STW  (STW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_opcode       (in_opcode),
        .in_alu_result   (in_alu_result),
        .in_store_data   (in_store_data),
        .in_dst          (in_dst),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_ack         (mem_ack),
        .mem_rdata       (mem_rdata),
        .wb_valid        (wb_valid),
        .wb_opcode       (wb_opcode),
        .wb_from_mem     (wb_from_mem),
        .wb_not_from_mem (wb_not_from_mem),
        .wb_dst          (wb_dst),
        .wb_fault        (wb_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One instruction; delay = wait cycles before ack (>= TO means never acked).
    task automatic do_op(input logic [5:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] dst,
                         input int delay, input logic [31:0] rdata);
        logic is_mem;
        logic mis;
        logic done;
        logic faulted;
        is_mem = (op == LDW) || (op == STW);
        mis    = is_mem && (addr[1:0] != 2'b00);
        chk("ready_pre", 32'(in_ready), 32'd1);
        in_valid      = 1'b1;
        in_opcode     = op;
        in_alu_result = addr;
        in_store_data = wdata;
        in_dst        = dst;
        tick();
        in_valid      = 1'b0;
        in_opcode     = 6'($urandom);
        in_alu_result = $urandom;
        in_store_data = $urandom;
        if (!is_mem || mis) begin
            chk("pt_valid", 32'(wb_valid), 32'd1);
            chk("pt_fault", 32'(wb_fault), 32'(mis));
            chk("pt_from_mem", wb_from_mem, 32'd0);
            chk("pt_nfm", wb_not_from_mem, addr);
            chk("pt_dst", 32'(wb_dst), 32'(dst));
            chk("pt_op", 32'(wb_opcode), 32'(op));
            chk("pt_no_req", 32'(mem_req), 32'd0);
            chk("pt_ready", 32'(in_ready), 32'd1);
        end else begin
            done = 1'b0;
            for (int c = 1; c <= int'(TO) && !done; c++) begin
                chk("req_hi", 32'(mem_req), 32'd1);
                chk("req_we", 32'(mem_we), 32'(op == STW));
                chk("req_addr", mem_addr, addr);
                chk("req_wdata", mem_wdata, wdata);
                chk("busy_ready", 32'(in_ready), 32'd0);
                chk("busy_no_wb", 32'(wb_valid), 32'd0);
                if (c - 1 == delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rdata;
                end else begin
                    mem_rdata = $urandom;
                end
                tick();
                mem_ack = 1'b0;
                if (c - 1 == delay || c == int'(TO)) begin
                    done    = 1'b1;
                    faulted = (c - 1 != delay);
                    chk("mem_valid", 32'(wb_valid), 32'd1);
                    chk("mem_fault", 32'(wb_fault), 32'(faulted));
                    chk("mem_from_mem", wb_from_mem,
                        (op == LDW && !faulted) ? rdata : 32'd0);
                    chk("mem_nfm", wb_not_from_mem, addr);
                    chk("mem_dst", 32'(wb_dst), 32'(dst));
                    chk("mem_op", 32'(wb_opcode), 32'(op));
                    chk("mem_req_drop", 32'(mem_req), 32'd0);
                    chk("mem_ready", 32'(in_ready), 32'd1);
                end
            end
        end
        // Spurious ack while idle; wb_valid must be a single pulse and data held.
        mem_ack   = 1'b1;
        mem_rdata = $urandom;
        tick();
        mem_ack = 1'b0;
        chk("pulse_end", 32'(wb_valid), 32'd0);
        chk("idle_no_req", 32'(mem_req), 32'd0);
        chk("idle_ready", 32'(in_ready), 32'd1);
        chk("hold_nfm", wb_not_from_mem, addr);
        chk("hold_dst", 32'(wb_dst), 32'(dst));
    endtask

    initial begin
        logic [5:0]  op;
        logic [31:0] a;
        int          sel;
        total         = 0;
        bad           = 0;
        rst_n         = 1'b0;
        in_valid      = 1'b0;
        in_opcode     = '0;
        in_alu_result = '0;
        in_store_data = '0;
        in_dst        = '0;
        mem_ack       = 1'b0;
        mem_rdata     = '0;

        #12;
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_op", 32'(wb_opcode), 32'd0);
        chk("rst_wb_fm", wb_from_mem, 32'd0);
        chk("rst_wb_nfm", wb_not_from_mem, 32'd0);
        chk("rst_wb_dst", 32'(wb_dst), 32'd0);
        chk("rst_wb_fault", 32'(wb_fault), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Directed cases
        do_op(6'h01, 32'h0000_1234, 32'h0, 5'd3, 0, 32'h0);
        do_op(LDW, 32'h0000_0100, 32'h0, 5'd7, 2, 32'hDEAD_BEEF);
        do_op(STW, 32'h0000_0204, 32'h55AA_55AA, 5'd9, 0, 32'h1234_5678);
        do_op(LDW, 32'h0000_0102, 32'h0, 5'd4, 0, 32'h0);
        do_op(LDW, 32'h0000_0300, 32'h0, 5'd5, 99, 32'hCAFE_F00D);
        do_op(LDW, 32'h0000_0304, 32'h0, 5'd6, int'(TO) - 1, 32'hA5A5_0001);

        // Back-to-back pass-through ops, one per cycle
        for (int i = 0; i < 3; i++) begin
            in_valid      = 1'b1;
            in_opcode     = 6'(i + 2);
            in_alu_result = 32'h1000 + 32'(i);
            in_dst        = 5'(10 + i);
            tick();
            chk("b2b_valid", 32'(wb_valid), 32'd1);
            chk("b2b_nfm", wb_not_from_mem, 32'h1000 + 32'(i));
            chk("b2b_dst", 32'(wb_dst), 32'(10 + i));
        end
        in_valid = 1'b0;
        tick();
        chk("b2b_end", 32'(wb_valid), 32'd0);

        // Reset during the second BUSY cycle of an LDW
        in_valid      = 1'b1;
        in_opcode     = LDW;
        in_alu_result = 32'h0000_0400;
        in_dst        = 5'd12;
        tick();
        in_valid = 1'b0;
        chk("rb_req1", 32'(mem_req), 32'd1);
        tick();
        chk("rb_req2", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rb_req_async", 32'(mem_req), 32'd0);
        chk("rb_ready", 32'(in_ready), 32'd1);
        chk("rb_no_wb", 32'(wb_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rb_after_wb", 32'(wb_valid), 32'd0);
        chk("rb_after_req", 32'(mem_req), 32'd0);
        do_op(LDW, 32'h0000_0408, 32'h0, 5'd13, 1, 32'h0BAD_CAFE);

        // Randomized traffic
        for (int n = 0; n < 80; n++) begin
            sel = int'($urandom_range(0, 2));
            if (sel == 0)      op = LDW;
            else if (sel == 1) op = STW;
            else begin
                op = 6'($urandom);
                if (op == LDW || op == STW) op = op ^ 6'h01;
            end
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            do_op(op, a, $urandom, 5'($urandom), int'($urandom_range(0, TO + 1)),
                  $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage of the pipelined core, between execute and writeback. It accepts one instruction at a time from execute. For `LDW`/`STW` it runs a request/acknowledge transaction with data memory, with a timeout. It then registers the `from_mem` / `not_from_mem` / `opcode` bundle that the writeback data selector consumes. Non-memory instructions pass through with one cycle of latency.

## Interface
Parameters:
- `TIMEOUT`, 255: maximum cycles spent waiting for `mem_ack` before the access is abandoned (1..255).

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  execute presents an instruction.
- `in_ready`  out  1  stage can accept; `in_ready = (state == IDLE)`.
- `in_opcode`  in  6  opcode; encodings from `def.v` (`LDW`, `STW`).
- `in_alu_result`  in  32  ALU result; effective address for `LDW`/`STW`.
- `in_store_data`  in  32  store data for `STW`.
- `in_dst`  in  5  destination register index.
- `mem_req`  out  1  memory request, registered.
- `mem_we`  out  1  1 = write (`STW`), 0 = read.
- `mem_addr`  out  32  word-aligned byte address.
- `mem_wdata`  out  32  write data.
- `mem_ack`  in  1  memory completes the current request this cycle.
- `mem_rdata`  in  32  read data, valid when `mem_ack` is high.
- `wb_valid`  out  1  one-cycle pulse: the `wb_*` bundle is new.
- `wb_opcode`  out  6  opcode of the completed instruction.
- `wb_from_mem`  out  32  load data; 0 for non-`LDW` and for faulted accesses.
- `wb_not_from_mem`  out  32  copy of `in_alu_result`.
- `wb_dst`  out  5  destination register.
- `wb_fault`  out  1  access was misaligned or timed out.

## Operation
- States: `IDLE`, `BUSY`.
- `IDLE`, accept on `in_valid & in_ready`. The instruction fields are latched.
- Non-memory opcode at accept:
  - the next edge loads the `wb_*` bundle and pulses `wb_valid`;
  - `wb_from_mem` = 0, `wb_fault` = 0;
  - the stage stays in `IDLE`.
- `LDW`/`STW` with `in_alu_result[1:0] != 0` (misaligned):
  - no memory request is issued;
  - next edge: `wb_valid` = 1, `wb_fault` = 1, `wb_from_mem` = 0;
  - the stage stays in `IDLE`.
- Aligned `LDW`/`STW` at accept:
  - next edge: `mem_req` = 1, `mem_we` = (opcode == `STW`), `mem_addr`/`mem_wdata` loaded, wait counter cleared to 0;
  - the stage goes to `BUSY`.
- `BUSY`:
  - `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` stay stable until the request ends.
  - Each cycle without `mem_ack`, the counter increments.
  - On a cycle with `mem_ack` = 1, the next edge:
    - sets `mem_req` = 0;
    - pulses `wb_valid`;
    - loads `wb_from_mem` = `mem_rdata` for `LDW`, 0 for `STW`;
    - sets `wb_fault` = 0;
    - returns to `IDLE`.
  - If the counter equals `TIMEOUT - 1` and `mem_ack` = 0, the next edge:
    - sets `mem_req` = 0;
    - pulses `wb_valid` with `wb_fault` = 1 and `wb_from_mem` = 0;
    - returns to `IDLE`.
  - If `mem_ack` arrives in the timeout cycle, the ack wins and there is no fault.
- `mem_ack` outside `BUSY` (late or spurious) is ignored.
- `wb_*` data fields hold their values between pulses. Writeback has no backpressure.

## Timing
- Reset (async, immediate):
  - state `IDLE`, counter 0;
  - `mem_req`, `mem_we`, `mem_addr`, `mem_wdata` = 0;
  - `wb_valid`, `wb_opcode`, `wb_from_mem`, `wb_not_from_mem`, `wb_dst`, `wb_fault` = 0;
  - `in_ready` = 1.
- Reset asserted mid-`BUSY` drops `mem_req` asynchronously. No `wb_valid` is produced for the abandoned instruction.
- Latency, counted from the accept edge:
  - non-memory or misaligned: `wb_valid` in the next cycle (1);
  - memory op: `mem_req` high in cycle 1; with `mem_ack` in cycle 1 + N (N ≥ 0 wait cycles), `wb_valid` is in cycle 2 + N;
  - timeout: `wb_valid` in cycle 1 + `TIMEOUT`, with `mem_req` high for exactly `TIMEOUT` cycles.
- Throughput: one non-memory instruction per cycle. `in_ready` is low for the whole `BUSY` period, including the ack cycle.
- `mem_req` never stays high in the cycle after an acknowledged cycle. Back-to-back memory ops have at least one `mem_req` = 0 cycle between them.

## Test plan
- Reset release, then a non-`LDW`/`STW` opcode with `in_alu_result` = 0x0000_1234 and `in_dst` = 3. Required: `wb_valid` one cycle later, `wb_not_from_mem` = 0x1234, `wb_from_mem` = 0, `wb_dst` = 3, `mem_req` never high.
- `LDW` at address 0x100; memory acks after 2 wait cycles with `mem_rdata` = 0xDEAD_BEEF. Required:
  - `mem_req` high for 3 cycles, `mem_we` = 0, `mem_addr` = 0x100;
  - `in_ready` low throughout `BUSY`;
  - `wb_valid` at cycle 4 with `wb_from_mem` = 0xDEAD_BEEF and `wb_fault` = 0.
- `STW` at address 0x204 with data 0x55AA_55AA; ack in the first request cycle. Required: `mem_we` = 1, `mem_wdata` = 0x55AA_55AA, `wb_valid` at cycle 2, `wb_from_mem` = 0.
- `LDW` at address 0x102. Required: no `mem_req`; `wb_valid` next cycle with `wb_fault` = 1.
- `TIMEOUT` = 4 and `mem_ack` held low. Required:
  - `mem_req` high for exactly 4 cycles;
  - `wb_fault` = 1 pulse;
  - a later `mem_ack` is ignored, with no second `wb_valid`.
- `rst_n` pulsed low during the second `BUSY` cycle of an `LDW`. Required: `mem_req` = 0 immediately, no `wb_valid`, `in_ready` = 1, and the next `LDW` completes normally.
